firebird7_in_gate1_tessent_tdr_w19_ctl: RTL and testbench
=========================================================

Name: firebird7_in_gate1_tessent_tdr_w19_ctl

Overview:
- IJTAG test data register that sits directly upstream of the 19-bit functional/IJTAG data mux.
- Drives the mux's `ijtag_data_in` and `ijtag_select` from a serially loaded shift register with capture, shift and update stages.
- Captures the mux's `data_out` for readback.
- Sequences the select output make-before-break, so the mux never switches onto data that is still changing.

Parameters:
- DATA_WIDTH, 19: width of the data field delivered to the mux.
- RESET_DATA, 19'h0: reset value of the shift and update data registers.
- RESET_SELECT, 1'b0: reset value of the select control bit.

Ports:
- ijtag_tck  input  1  single clock; all state updates on the rising edge.
- ijtag_reset  input  1  reset, synchronous, active-high.
- ijtag_sel  input  1  TDR selected in the active scan path.
- ijtag_ce  input  1  capture enable.
- ijtag_se  input  1  shift enable.
- ijtag_ue  input  1  update enable.
- ijtag_si  input  1  scan in.
- ijtag_so  output  1  scan out; equals shift-register bit 0.
- capture_data_in  input  DATA_WIDTH  readback of the mux `data_out`.
- ijtag_data_out  output  DATA_WIDTH  to the mux `ijtag_data_in`.
- ijtag_select_out  output  1  to the mux `ijtag_select`.

Behaviour:
- Shift register `sr`:
  - Width is DATA_WIDTH+1.
  - Bit DATA_WIDTH is the select bit; bits DATA_WIDTH-1:0 are the data field.
- Reset (ijtag_reset=1 at the edge):
  - sr = {RESET_SELECT, RESET_DATA}.
  - Update data register = RESET_DATA.
  - Requested select = RESET_SELECT.
  - FSM = IDLE.
  - ijtag_select_out = RESET_SELECT.
  - ijtag_so = RESET_DATA[0].
  - Reset overrides all other operations, including mid-shift and pending ARM.
- Shift (ijtag_sel & ijtag_se):
  - sr <= {ijtag_si, sr[DATA_WIDTH:1]}; LSB exits first.
  - ijtag_so is the registered sr[0]; no combinational path from si.
- Capture (ijtag_sel & ijtag_ce & ~ijtag_se):
  - sr <= {ijtag_select_out, capture_data_in}.
  - Shift wins if ce and se are both high.
- Update (ijtag_sel & ijtag_ue):
  - Update registers load the pre-edge sr value.
  - Update concurrent with shift or capture uses the old sr.
- ijtag_sel=0: sr, update registers and FSM inputs hold. An in-flight ARM still completes.
- Select sequencing FSM (IDLE, ARM):
  - IDLE, update with new select=1 and output currently 0: data register loads this edge, ijtag_select_out stays 0, go to ARM.
  - ARM, next edge (unconditional): ijtag_select_out <= 1, go to IDLE. Data output is stable for ≥1 cycle before select rises.
  - Update with select=0: ijtag_select_out <= 0 on the same edge (break immediately); data loads on the same edge. Go to/stay IDLE, cancelling ARM.
  - Update during ARM with select=1: new data loads, stay in ARM, one more cycle before select rises.
  - Update with select=1 while output already 1: data loads and select stays 1, no gap.
- Latency:
  - Data: 1 cycle from update edge to ijtag_data_out.
  - Select rise: 2 cycles.
  - Select fall: 1 cycle.
- All outputs registered. No X on any output after the first reset edge.

Decomposition:
- Shared package firebird7_in_gate1_tessent_tdr_pkg:
  - tdr_state_e {IDLE, ARM}.
  - Localparam SR_WIDTH = DATA_WIDTH+1.
  - Constant SEL_BIT = DATA_WIDTH.
- One natural sub-module: firebird7_in_gate1_tessent_tdr_sel_seq, the two-state select sequencer.
- Shift, capture and update logic stay in the top module.

Test Plan:
- Reset then idle: ijtag_reset=1 for 1 cycle → ijtag_data_out=19'h0, ijtag_select_out=0, ijtag_so=0; hold 5 cycles with sel=0 → no output change.
- Shift and update with select: shift 20 bits of {1, 19'h5A5A5} LSB-first, then pulse ue → ijtag_data_out=19'h5A5A5 at +1 cycle; ijtag_select_out rises at +2 cycles, not +1.
- Capture and readback: capture_data_in=19'h7_1234 with select_out=1, pulse ce, shift 20 cycles → so stream is 19'h71234 LSB-first followed by 1.
- Break immediately: with select_out=1, load {0, 19'h00FF} and update → select_out=0 and data=19'h00FF on the same edge.
- Simultaneous events:
  - ce and se both high → shift occurs, not capture.
  - ue during shift → update takes the pre-shift sr.
  - Update with select=0 during ARM → select_out stays 0.
- Reset mid-operation: assert reset in the ARM cycle and after 7 shift bits → select_out=0, sr=reset value, FSM=IDLE on the next edge.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared types and constants for the firebird7 IJTAG test data register
// that feeds the 19-bit functional/IJTAG data mux.
package firebird7_in_gate1_tessent_tdr_pkg;

    localparam int TDR_DATA_WIDTH = 19;
    localparam int SR_WIDTH       = TDR_DATA_WIDTH + 1;
    localparam int SEL_BIT        = TDR_DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        ARM  = 1'b1
    } tdr_state_e;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_sel_seq.sv
// Make-before-break sequencer for the mux select: a rising select waits one
// cycle in ARM so the data register is already stable; a falling select breaks at once.
module firebird7_in_gate1_tessent_tdr_sel_seq
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter logic RESET_SELECT = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_update,
    input  logic i_req_sel,
    output logic o_select
);

    tdr_state_e r_state;
    tdr_state_e w_next_state;
    logic       r_select;
    logic       w_next_select;
    logic       r_req_sel;
    logic       w_next_req_sel;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_select  <= RESET_SELECT;
            r_req_sel <= RESET_SELECT;
        end else begin
            r_state   <= w_next_state;
            r_select  <= w_next_select;
            r_req_sel <= w_next_req_sel;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        w_next_state   = r_state;
        w_next_select  = r_select;
        w_next_req_sel = i_update ? i_req_sel : r_req_sel;
        case (r_state)
            IDLE: begin
                if (i_update) begin
                    if (!i_req_sel) begin
                        w_next_select = 1'b0;
                    end else if (!r_select) begin
                        w_next_state = ARM;
                    end
                end
            end
            ARM: begin
                // A fresh update restarts the wait; a deselect cancels it outright.
                if (i_update) begin
                    if (!i_req_sel) begin
                        w_next_select = 1'b0;
                        w_next_state  = IDLE;
                    end
                end else begin
                    w_next_select = r_req_sel;
                    w_next_state  = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_select = r_select;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// IJTAG TDR driving the 19-bit data mux: scan shift register with capture of
// the mux readback, an update data register, and a sequenced select output.
module firebird7_in_gate1_tessent_tdr_w19_ctl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int                    DATA_WIDTH   = TDR_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA   = '0,
    parameter logic                  RESET_SELECT = 1'b0
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] capture_data_in,
    output logic [DATA_WIDTH-1:0] ijtag_data_out,
    output logic                  ijtag_select_out
);

    logic [DATA_WIDTH:0]   r_sr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_shift;
    logic                  w_capture;
    logic                  w_update;

    assign w_shift   = ijtag_sel & ijtag_se;
    assign w_capture = ijtag_sel & ijtag_ce & ~ijtag_se;
    assign w_update  = ijtag_sel & ijtag_ue;

    // Capture records the select currently driven, not the one requested.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_sr <= {RESET_SELECT, RESET_DATA};
        end else if (w_shift) begin
            r_sr <= {ijtag_si, r_sr[DATA_WIDTH:1]};
        end else if (w_capture) begin
            r_sr <= {ijtag_select_out, capture_data_in};
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_data <= RESET_DATA;
        end else if (w_update) begin
            r_data <= r_sr[DATA_WIDTH-1:0];
        end
    end

    firebird7_in_gate1_tessent_tdr_sel_seq #(
        .RESET_SELECT (RESET_SELECT)
    ) u_sel_seq (
        .i_clk     (ijtag_tck),
        .i_reset   (ijtag_reset),
        .i_update  (w_update),
        .i_req_sel (r_sr[DATA_WIDTH]),
        .o_select  (ijtag_select_out)
    );

    assign ijtag_so       = r_sr[0];
    assign ijtag_data_out = r_data;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// Directed bench for the firebird7 TDR: a timeline-based behavioural model is
// compared every cycle, and literal expectations pin the key scenarios.
module tb_firebird7_in_gate1_tessent_tdr_w19_ctl;
    import firebird7_in_gate1_tessent_tdr_pkg::*;

    logic        tck = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        ce  = 1'b0;
    logic        se  = 1'b0;
    logic        ue  = 1'b0;
    logic        si  = 1'b0;
    logic [18:0] cap = '0;
    logic        so;
    logic [18:0] data_out;
    logic        sel_out;

    int n_vec = 0;
    int n_err = 0;

    firebird7_in_gate1_tessent_tdr_w19_ctl dut (
        .ijtag_tck        (tck),
        .ijtag_reset      (rst),
        .ijtag_sel        (sel),
        .ijtag_ce         (ce),
        .ijtag_se         (se),
        .ijtag_ue         (ue),
        .ijtag_si         (si),
        .ijtag_so         (so),
        .capture_data_in  (cap),
        .ijtag_data_out   (data_out),
        .ijtag_select_out (sel_out)
    );

    always #5 tck = ~tck;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: select rise is a scheduled edge number rather than a state machine.
    logic [SR_WIDTH-1:0] m_sr = '0;
    logic [18:0]         m_data = '0;
    logic                m_sel = 1'b0;
    bit                  m_valid = 1'b0;
    int                  edge_n = 0;
    int                  rise_at = -1;

    always @(posedge tck) begin
        logic [SR_WIDTH-1:0] old_sr;
        logic                new_sel;
        edge_n++;
        if (rst) begin
            m_sr    = '0;
            m_data  = '0;
            m_sel   = 1'b0;
            rise_at = -1;
            m_valid = 1'b1;
        end else begin
            old_sr  = m_sr;
            new_sel = m_sel;
            if (rise_at == edge_n) begin
                new_sel = 1'b1;
                rise_at = -1;
            end
            if (sel && ue) begin
                m_data = old_sr[18:0];
                if (!old_sr[SEL_BIT]) begin
                    new_sel = 1'b0;
                    rise_at = -1;
                end else if (!m_sel) begin
                    new_sel = 1'b0;
                    rise_at = edge_n + 1;
                end
            end
            if (sel && se)      m_sr = {si, old_sr[SR_WIDTH-1:1]};
            else if (sel && ce) m_sr = {m_sel, cap};
            m_sel = new_sel;
        end
    end

    always @(negedge tck) begin
        if (m_valid) begin
            check("model_data", 32'(data_out), 32'(m_data));
            check("model_select", 32'(sel_out), 32'(m_sel));
            check("model_so", 32'(so), 32'(m_sr[0]));
        end
    end

    task automatic drive(input logic r, input logic s, input logic c, input logic e,
                         input logic u, input logic d);
        rst = r; sel = s; ce = c; se = e; ue = u; si = d;
        @(negedge tck);
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic shift_vec(input logic [SR_WIDTH-1:0] v, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, v[i]);
    endtask

    initial begin
        logic [SR_WIDTH-1:0] stream;

        // Reset, then hold with the TDR deselected while other controls toggle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_data", 32'(data_out), 32'h0);
        check("reset_select", 32'(sel_out), 32'h0);
        check("reset_so", 32'(so), 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, i[0], i[1], 1'b1, 1'b1);
            check("desel_hold_data", 32'(data_out), 32'h0);
            check("desel_hold_select", 32'(sel_out), 32'h0);
        end

        // Shift {1, 19'h5A5A5} and update: data at +1, select at +2
        shift_vec(20'hDA5A5, 20);
        update();
        check("upd_data_plus1", 32'(data_out), 32'h5A5A5);
        check("upd_select_plus1", 32'(sel_out), 32'h0);
        idle();
        check("upd_select_plus2", 32'(sel_out), 32'h1);

        // Capture readback with select_out=1, then shift it all out
        cap = 19'h71234;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < SR_WIDTH; i++) begin
            stream[i] = so;
            shift_vec(20'h0, 1);
        end
        check("capture_stream", 32'(stream), 32'hF1234);

        // Deselect breaks on the same edge the data loads
        shift_vec(20'h000FF, 20);
        update();
        check("break_select", 32'(sel_out), 32'h0);
        check("break_data", 32'(data_out), 32'h000FF);

        // ce and se together: shift wins
        shift_vec(20'h00003, 20);
        cap = 19'h7FFFE;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ce_se_shift_wins", 32'(so), 32'h1);

        // Update during shift takes the pre-shift register
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("upd_during_shift", 32'(data_out), 32'h1);
        check("upd_during_shift_so", 32'(so), 32'h0);

        // Arm with concurrent capture, then deselect while armed
        shift_vec(20'h92345, 20);
        cap = 19'h2AAAA;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("arm_cap_data", 32'(data_out), 32'h12345);
        check("arm_cap_select", 32'(sel_out), 32'h0);
        update();
        check("arm_cancel_data", 32'(data_out), 32'h2AAAA);
        check("arm_cancel_select", 32'(sel_out), 32'h0);
        idle();
        idle();
        check("arm_cancel_hold", 32'(sel_out), 32'h0);

        // Re-update with select=1 while armed delays the rise by one cycle
        shift_vec(20'hC0001, 20);
        update();
        update();
        check("rearm_select", 32'(sel_out), 32'h0);
        check("rearm_data", 32'(data_out), 32'h40001);
        idle();
        check("rearm_rise", 32'(sel_out), 32'h1);

        // Select already high: no gap
        shift_vec(20'h80055, 20);
        update();
        check("nogap_select", 32'(sel_out), 32'h1);
        check("nogap_data", 32'(data_out), 32'h00055);

        // Reset in the ARM cycle
        shift_vec(20'h00000, 20);
        update();
        shift_vec(20'h80777, 20);
        update();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_arm_select", 32'(sel_out), 32'h0);
        check("rst_arm_data", 32'(data_out), 32'h0);
        idle();
        idle();
        check("rst_arm_no_rise", 32'(sel_out), 32'h0);

        // Reset after 7 shift bits restores the shift register
        shift_vec(20'hFFFFF, 7);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_shift_so", 32'(so), 32'h0);
        update();
        check("rst_shift_sr_data", 32'(data_out), 32'h0);
        check("rst_shift_sr_select", 32'(sel_out), 32'h0);

        // An armed rise completes even when the TDR is deselected
        shift_vec(20'h80011, 20);
        update();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("desel_arm_completes", 32'(sel_out), 32'h1);
        check("desel_arm_data", 32'(data_out), 32'h00011);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
